// File: rtl/uart_rx_oversample.sv
// ---------------------------------------------------------------------------
// uart_rx_oversample
//
// 16x-oversampling UART receiver, 8N1, LSB first. Converts the asynchronous
// rxd pin into bytes for the peripheral bus block.
//
// Ports
//   clk        in   system clock, everything on the rising edge
//   reset      in   asynchronous, active-high, clears all state
//   rxd        in   serial line, idle high, asynchronous to clk
//   rx_data    out  [7:0] last correctly framed byte
//   rx_status  out  high from byte completion until the next valid start bit
//   rx_valid   out  one-cycle pulse when rx_data updates
//   frame_err  out  one-cycle pulse when the stop bit samples low
//   busy       out  high whenever the receiver is not idle
//
// Parameter
//   DIV        system clocks per 16x sample tick, legal range 2..65535
//
// State table
//   state   | meaning
//   S_IDLE  | line idle, waiting for a low level on the synchronized input
//   S_START | qualifying the start bit; a high vote rejects it as a glitch
//   S_DATA  | shifting in the eight data bits, LSB first
//   S_STOP  | checking the stop bit at mid-bit
//   S_BREAK | stop bit was low; wait for the line to return high
// ---------------------------------------------------------------------------
module uart_rx_oversample #(
    parameter int unsigned DIV = 326
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_status,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] TICK_TC = 16'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t      r_state;

    logic        r_sync1;
    logic        r_sync2;
    logic [15:0] r_tcnt;
    logic [3:0]  r_scnt;
    logic [2:0]  r_bcnt;
    logic        r_v7;
    logic        r_v8;
    logic [7:0]  r_shreg;

    logic [7:0]  r_rx_data;
    logic        r_rx_status;
    logic        r_rx_valid;
    logic        r_frame_err;
    logic        r_busy;

    logic        w_rxs;
    logic        w_tick;
    logic        w_vote;
    logic        w_mid;
    logic        w_end;

    // -----------------------------------------------------------------------
    // Two-flop synchronizer; both stages reset to the idle (high) level so a
    // reset never looks like a start edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // -----------------------------------------------------------------------
    // Sample tick generator. Held at zero while idle, so the first count of a
    // frame starts on the cycle the FSM enters S_START and every sample point
    // is referenced to the detected falling edge.
    // -----------------------------------------------------------------------
    assign w_tick = (r_tcnt == TICK_TC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcnt <= 16'd0;
        end else if (r_state == S_IDLE) begin
            r_tcnt <= 16'd0;
        end else if (w_tick) begin
            r_tcnt <= 16'd0;
        end else begin
            r_tcnt <= r_tcnt + 16'd1;
        end
    end

    // Majority of the samples at scnt 7, 8 and 9; the third sample is the
    // live synchronized input on the scnt=9 tick.
    assign w_vote = (r_v7 & r_v8) | (r_v7 & w_rxs) | (r_v8 & w_rxs);

    assign w_mid  = w_tick && (r_scnt == 4'd9);
    assign w_end  = w_tick && (r_scnt == 4'd15);

    // -----------------------------------------------------------------------
    // Receive FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_scnt      <= 4'd0;
            r_bcnt      <= 3'd0;
            r_v7        <= 1'b1;
            r_v8        <= 1'b1;
            r_shreg     <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_status <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_tick && (r_scnt == 4'd7)) begin
                r_v7 <= w_rxs;
            end
            if (w_tick && (r_scnt == 4'd8)) begin
                r_v8 <= w_rxs;
            end

            // scnt is cleared while idle so a frame accepted on the very
            // first idle cycle still starts counting from zero.
            if (r_state == S_IDLE) begin
                r_scnt <= 4'd0;
            end else if (w_tick) begin
                r_scnt <= r_scnt + 4'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_mid) begin
                        if (w_vote) begin
                            // Low pulse too short to be a start bit.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_rx_status <= 1'b0;
                        end
                    end else if (w_end) begin
                        r_state <= S_DATA;
                        r_bcnt  <= 3'd0;
                    end
                end

                S_DATA: begin
                    if (w_mid) begin
                        // Shift in at the MSB; after eight bits the first
                        // bit received sits in bit 0.
                        r_shreg <= {w_vote, r_shreg[7:1]};
                    end else if (w_end) begin
                        if (r_bcnt == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bcnt <= r_bcnt + 3'd1;
                        end
                    end
                end

                S_STOP: begin
                    // Leaving at mid stop bit gives half a bit of margin to
                    // resynchronise on a back-to-back start edge.
                    if (w_mid) begin
                        if (w_vote) begin
                            r_rx_data   <= r_shreg;
                            r_rx_valid  <= 1'b1;
                            r_rx_status <= 1'b1;
                            r_state     <= S_IDLE;
                            r_busy      <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end
                end

                S_BREAK: begin
                    // A held-low line reports a single frame error.
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_status = r_rx_status;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_oversample.sv
module tb_uart_rx_oversample;

    localparam int DIV     = 4;
    localparam int BIT_CLK = 16 * DIV;
    localparam int LAT_NOM = (1 + 8) * 16 * DIV + 10 * DIV;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    uart_rx_oversample #(.DIV(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_status (rx_status),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model: bytes expected on the bus, expected status level,
    // expected pulse counts, last good byte
    logic [7:0] exp_q[$];
    logic       exp_status = 1'b0;
    logic [7:0] last_byte  = 8'h00;
    int         exp_valid  = 0;
    int         exp_ferr   = 0;

    int n_valid = 0;
    int n_ferr  = 0;
    int t_fall  = 0;

    logic prev_valid  = 1'b0;
    logic prev_ferr   = 1'b0;
    logic prev_status = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // output monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                int lat;
                logic [7:0] e;
                n_valid++;
                lat = cyc - t_fall;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(rx_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", 32'(rx_data), 32'(e));
                end
                chk($sformatf("latency_window lat=%0d", lat),
                    32'((lat >= LAT_NOM - 2) && (lat <= LAT_NOM + 6)), 32'd1);
                chk("status_with_valid", 32'(rx_status), 32'd1);
                chk("valid_ferr_excl", 32'(frame_err), 32'd0);
            end
            if (frame_err) n_ferr++;
            if (prev_valid) chk("valid_width", 32'(rx_valid), 32'd0);
            if (prev_ferr)  chk("ferr_width", 32'(frame_err), 32'd0);
            if (!prev_status && rx_status) chk("status_rise_at_valid", 32'(rx_valid), 32'd1);
            prev_valid  = rx_valid;
            prev_ferr   = frame_err;
            prev_status = rx_status;
        end else begin
            prev_valid  = 1'b0;
            prev_ferr   = 1'b0;
            prev_status = 1'b0;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        wait_clk(n);
    endtask

    // abort_bit < 0: full frame; otherwise reset is pulsed inside that data bit
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int abort_bit);
        chk("status_pre_frame", 32'(rx_status), 32'(exp_status));
        if (stop_ok && abort_bit < 0) begin
            exp_q.push_back(b);
            exp_valid++;
        end
        rxd    = 1'b0;
        t_fall = cyc;
        wait_clk(52);
        chk("status_in_start", 32'(rx_status), 32'd0);
        wait_clk(BIT_CLK - 52);
        exp_status = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            if (i == abort_bit) begin
                wait_clk(30);
                reset = 1'b1;
                #1;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_data", 32'(rx_data), 32'd0);
                chk("abort_status", 32'(rx_status), 32'd0);
                chk("abort_valid", 32'(rx_valid), 32'd0);
                wait_clk(5);
                reset     = 1'b0;
                last_byte = 8'h00;
                rxd       = 1'b1;
                wait_clk(BIT_CLK);
                chk("abort_idle_busy", 32'(busy), 32'd0);
                return;
            end
            wait_clk(BIT_CLK);
        end
        rxd = stop_ok;
        wait_clk(BIT_CLK);
        if (stop_ok) begin
            exp_status = 1'b1;
            last_byte  = b;
        end else begin
            exp_ferr++;
        end
    endtask

    initial begin
        int ferr0;
        int vcnt0;

        reset = 1'b1;
        rxd   = 1'b1;
        wait_clk(5);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_status", 32'(rx_status), 32'd0);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        wait_clk(1000);
        chk("post_rst_data", 32'(rx_data), 32'd0);
        chk("post_rst_status", 32'(rx_status), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_nvalid", 32'(n_valid), 32'd0);

        // single byte
        send_frame(8'hA5, 1'b1, -1);
        idle(40);
        chk("a5_data", 32'(rx_data), 32'(last_byte));
        chk("a5_status", 32'(rx_status), 32'(exp_status));
        chk("a5_ferr", 32'(n_ferr), 32'(exp_ferr));

        // back-to-back, no gap
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h55, 1'b1, -1);
        idle(100);
        chk("b2b_nvalid", 32'(n_valid), 32'(exp_valid));
        chk("b2b_last", 32'(rx_data), 32'(last_byte));

        // short low glitch
        vcnt0 = n_valid;
        rxd = 1'b0;
        wait_clk(6);
        chk("glitch_busy_hi", 32'(busy), 32'd1);
        wait_clk(6);
        rxd = 1'b1;
        wait_clk(60);
        chk("glitch_busy_lo", 32'(busy), 32'd0);
        chk("glitch_novalid", 32'(n_valid - vcnt0), 32'd0);
        chk("glitch_data", 32'(rx_data), 32'(last_byte));
        chk("glitch_status", 32'(rx_status), 32'(exp_status));

        // framing error with line held low
        ferr0 = n_ferr;
        vcnt0 = n_valid;
        send_frame(8'h3C, 1'b0, -1);
        rxd = 1'b0;
        wait_clk(500);
        chk("break_busy", 32'(busy), 32'd1);
        rxd = 1'b1;
        wait_clk(20);
        chk("break_exit_busy", 32'(busy), 32'd0);
        chk("ferr_once", 32'(n_ferr - ferr0), 32'd1);
        chk("ferr_novalid", 32'(n_valid - vcnt0), 32'd0);
        chk("ferr_data_kept", 32'(rx_data), 32'(last_byte));
        send_frame(8'h81, 1'b1, -1);
        idle(40);
        chk("after_ferr_data", 32'(rx_data), 32'h81);

        // reset during data bit 4
        vcnt0 = n_valid;
        send_frame(8'hC3, 1'b1, 4);
        chk("abort_novalid", 32'(n_valid - vcnt0), 32'd0);
        send_frame(8'h7E, 1'b1, -1);
        idle(40);
        chk("after_abort_data", 32'(rx_data), 32'h7E);

        // randomized traffic
        for (int f = 0; f < 16; f++) begin
            logic [7:0] b;
            logic       ok;
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 99) >= 15);
            if ($urandom_range(0, 9) == 0) begin
                rxd = 1'b0;
                wait_clk($urandom_range(4, 16));
                idle(60);
            end
            send_frame(b, ok, -1);
            if (!ok) begin
                rxd = 1'b0;
                wait_clk($urandom_range(0, 200));
                idle($urandom_range(8, 60));
            end else begin
                idle($urandom_range(0, 80));
            end
        end

        idle(700);
        chk("final_nvalid", 32'(n_valid), 32'(exp_valid));
        chk("final_nferr", 32'(n_ferr), 32'(exp_ferr));
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_data", 32'(rx_data), 32'(last_byte));
        chk("final_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
